// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, using one full-subtractor cell and a registered borrow.
// Define SERIAL_SUBTRACTOR_OVERFLOW_EN to compute the signed overflow flag; otherwise overflow is 0.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, res_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             busy_q, done_q, borrow_q;
  logic [WIDTH-1:0] diff_q;

  logic             x_c, y_c, d_c, br_d;
  logic [WIDTH-1:0] res_d;
  logic             last_c;

  // Full-subtractor cell on the current LSBs
  always_comb begin
    x_c    = a_sr_q[0];
    y_c    = b_sr_q[0];
    d_c    = x_c ^ y_c ^ br_q;
    br_d   = (~x_c & y_c) | (~(x_c ^ y_c) & br_q);
    res_d  = {d_c, res_q[WIDTH-1:1]};
    last_c = (cnt_q == CW'(WIDTH - 1));
  end

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic a_msb_q, b_msb_q, ovf_q;

  // Captured operand sign bits; the result sign is the final cell output
  always_ff @(posedge clk) begin
    if (reset) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if ((state_q == IDLE || state_q == DONE) && start) begin
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1];
    end else if (state_q == RUN && last_c) begin
      ovf_q <= (a_msb_q != b_msb_q) && (d_c != a_msb_q);
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            a_sr_q  <= a;
            b_sr_q  <= b;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_sr_q <= a_sr_q >> 1;
          b_sr_q <= b_sr_q >> 1;
          res_q  <= res_d;
          br_q   <= br_d;
          cnt_q  <= cnt_q + CW'(1);
          if (last_c) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            diff_q   <= res_d;
            borrow_q <= br_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule
